// File: rtl/math_log2_32_pkg.sv
// math_pkg: fixed-point format shared by the log2/pow2 pair and the constant
// function that fills the log2 interpolation ROM.
//   LOG_INT_W / LOG_FRAC_W : result format, integer.fraction (6.6)
//   lut_entry(k, lut_w)    : round(log2(1 + k/64) * 2^lut_w), k = 0..64
package math_pkg;

    localparam int LOG_INT_W  = 6;
    localparam int LOG_FRAC_W = 6;
    localparam int LOG_W      = LOG_INT_W + LOG_FRAC_W;
    localparam int LUT_N      = 65;

    // Integer-only log2 by repeated squaring: y holds the mantissa in Q1.31.
    // Each squaring doubles the log; if the result reaches 2.0 the next bit of
    // log2 is a 1 and y is halved. One extra bit is produced for rounding.
    function automatic int unsigned lut_entry(input int unsigned k,
                                              input int unsigned lut_w);
        logic [63:0] y;
        int unsigned r;
        if (k >= 64) return 32'd1 << lut_w;
        y = 64'(64 + k) << 25;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i <= int'(lut_w)) begin
                y = (y * y) >> 31;
                r = r << 1;
                if (y >= 64'h1_0000_0000) begin
                    r = r | 32'd1;
                    y = y >> 1;
                end
            end
        end
        return (r + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/math_log2_32_if.sv
// math_log2_32_if: sample/result bundle for the log2 pipeline.
//   in_valid, din            : producer -> log2 (no backpressure)
//   out_valid, dout, out_zero: log2 -> consumer, one-cycle result pulse
interface math_log2_32_if
    import math_pkg::*;
#(
    parameter int DIN_W = 32
);
    logic             in_valid;
    logic [DIN_W-1:0] din;
    logic             out_valid;
    logic [LOG_W-1:0] dout;
    logic             out_zero;

    modport master (output in_valid, din, input out_valid, dout, out_zero);
    modport slave  (input in_valid, din, output out_valid, dout, out_zero);
endinterface

// File: rtl/math_log2_32_lzc.sv
// math_lzc: combinational leading-one position encoder.
//   din  : DIN_W-bit magnitude
//   idx  : index of the most significant set bit (0 when din == 0)
//   zero : din == 0
module math_lzc #(
    parameter int DIN_W = 32
) (
    input  logic [DIN_W-1:0] din,
    output logic [5:0]       idx,
    output logic             zero
);
    always_comb begin
        idx  = '0;
        zero = (din == '0);
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < DIN_W; i++) begin
            if (din[i]) idx = 6'(i);
        end
    end
endmodule

// File: rtl/math_log2_32.sv
// math_log2_32: 4-stage pipelined log2 of an unsigned magnitude, 6.6 fixed point.
//   clk, rst : clock, synchronous active-high reset
//   bus      : math_log2_32_if.slave (in_valid/din in, out_valid/dout/out_zero out)
// Stages: S1 register din + leading-one index, S2 normalise to 6-bit LUT index and
// 6-bit weight, S3 ROM lookup + linear interpolation, S4 fraction scaling/output.
// Build option: define MATH_LOG2_ROUND_EN to round the fraction half-up (carry may
// ripple into the integer part); otherwise the fraction is truncated.
module math_log2_32
    import math_pkg::*;
#(
    parameter int DIN_W = 32,
    parameter int LUT_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    math_log2_32_if.slave     bus
);
    localparam int STAGES = 4;
    localparam int AW     = LUT_W + 1;   // holds 2^LUT_W, the LUT[64] endpoint

    logic [STAGES:1] vld_pipe;

    // S1
    logic [DIN_W-1:0] din_s1;
    logic [5:0]       e_lzc, e_s1;
    logic             zero_lzc, zero_s1;

    // S2
    logic [6:0]       shamt;
    logic [11:0]      field;
    logic [5:0]       f_hi_s2, f_lo_s2, e_s2;
    logic             zero_s2;

    // S3
    logic [AW-1:0]    rom [0:LUT_N-1];
    logic [AW-1:0]    l0, l1, delta, interp, interp_s3;
    logic [AW+5:0]    prod;
    logic [5:0]       e_s3;
    logic             zero_s3;

    // S4
    logic [6:0]       frac;
    logic [LOG_W-1:0] result;

    math_lzc #(.DIN_W(DIN_W)) u_lzc (
        .din  (bus.din),
        .idx  (e_lzc),
        .zero (zero_lzc)
    );

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
    end

    // Shift so the leading one lands just above the 12 bits we keep; the
    // 12-bit cast drops that implicit one and zero-pads narrow inputs.
    assign shamt = 7'(DIN_W - 1) - {1'b0, e_s1};
    assign field = 12'(({din_s1, 12'b0} << shamt) >> (DIN_W - 1));

    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        assign rom[k] = AW'(lut_entry(k, LUT_W));
    end

    // LUT is monotonic, so delta never goes negative.
    assign l0     = rom[{1'b0, f_hi_s2}];
    assign l1     = rom[{1'b0, f_hi_s2} + 7'd1];
    assign delta  = l1 - l0;
    assign prod   = (AW + 6)'(delta) * (AW + 6)'(f_lo_s2);
    assign interp = l0 + AW'(prod >> 6);

`ifdef MATH_LOG2_ROUND_EN
    logic [AW-1:0] frac_sum;
    assign frac_sum = interp_s3 + AW'(1 << (LUT_W - 7));
    assign frac     = 7'(frac_sum >> (LUT_W - 6));
`else
    assign frac     = 7'(interp_s3 >> (LUT_W - 6));
`endif

    // frac may equal 64 when rounding, carrying into the integer field.
    assign result = zero_s3 ? '0 : ({e_s3, 6'b0} + LOG_W'(frac));

    always_ff @(posedge clk) begin
        din_s1    <= bus.din;
        e_s1      <= e_lzc;
        zero_s1   <= zero_lzc;

        f_hi_s2   <= field[11:6];
        f_lo_s2   <= field[5:0];
        e_s2      <= e_s1;
        zero_s2   <= zero_s1;

        interp_s3 <= interp;
        e_s3      <= e_s2;
        zero_s3   <= zero_s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout     <= '0;
            bus.out_zero <= 1'b0;
        end else if (vld_pipe[STAGES-1]) begin
            bus.dout     <= result;
            bus.out_zero <= zero_s3;
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_math_log2_32.sv
// Bench for math_log2_32: directed corner cases plus randomized samples checked
// against an ideal real-valued log2 model and a delayed-valid scoreboard.
module tb_math_log2_32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    math_log2_32_if #(.DIN_W(32)) bus ();

    math_log2_32 #(.DIN_W(32), .LUT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one clock of input, then sample 1 ns after the edge.
    task automatic cycle(input bit v, input logic [31:0] d);
        bus.in_valid = v;
        bus.din      = d;
        @(posedge clk);
        #1;
    endtask

    function automatic real ideal_log(input logic [31:0] d);
        return 64.0 * $ln(real'(d)) / $ln(2.0);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.dout !== 12'h000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d out_valid=%b dout=%h want 0/000", i, bus.out_valid, bus.dout);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.dout !== 12'h000) begin
                failures++;
                $display("FAIL reset_release cyc=%0d out_valid=%b dout=%h want 0/000", i, bus.out_valid, bus.dout);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'd1, 32'd2, 32'd3, 32'h1000};
        logic [11:0] exp  [4] = '{12'h000, 12'h040, 12'h065, 12'h300};
        for (int c = 0; c < 8; c++) begin
            if (c < 4) cycle(1'b1, vals[c]);
            else       cycle(1'b0, 32'h0);
            if (c >= 3 && c < 7) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.dout !== exp[c-3] || bus.out_zero !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b idx=%0d out_valid=%b dout=%h zero=%b want 1/%h/0",
                             c - 3, bus.out_valid, bus.dout, bus.out_zero, exp[c-3]);
                end
            end
        end
    endtask

    task automatic test_zero();
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      cycle(1'b1, 32'd0);
            else if (c == 1) cycle(1'b1, 32'd1);
            else             cycle(1'b0, 32'h0);
            if (c == 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_zero !== 1'b1 || bus.dout !== 12'h000) begin
                    failures++;
                    $display("FAIL zero_in out_valid=%b zero=%b dout=%h want 1/1/000", bus.out_valid, bus.out_zero, bus.dout);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_zero !== 1'b0 || bus.dout !== 12'h000) begin
                    failures++;
                    $display("FAIL one_in out_valid=%b zero=%b dout=%h want 1/0/000", bus.out_valid, bus.out_zero, bus.dout);
                end
            end
        end
    endtask

    task automatic test_max();
`ifdef MATH_LOG2_ROUND_EN
        logic [11:0] exp = 12'h800;
`else
        logic [11:0] exp = 12'h7FF;
`endif
        for (int c = 0; c < 5; c++) begin
            if (c == 0) cycle(1'b1, 32'hFFFF_FFFF);
            else        cycle(1'b0, 32'h0);
            if (c == 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.dout !== exp) begin
                    failures++;
                    $display("FAIL max_in out_valid=%b dout=%h want 1/%h", bus.out_valid, bus.dout, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        bit          hist[$];
        logic [31:0] dq[$];
        logic [11:0] last_dout = bus.dout;
        logic        last_zero = bus.out_zero;
        int          sent = 0;
        hist = '{1'b0, 1'b0, 1'b0};
        while (sent < 10000 || hist.size() > 0 && dq.size() > 0) begin
            bit          v;
            logic [31:0] d;
            v = (sent < 10000) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 15))
                0:       d = 32'd0;
                1:       d = 32'd1;
                2:       d = 32'hFFFF_FFFF;
                default: d = $urandom >> $urandom_range(0, 31);
            endcase
            cycle(v, d);
            if (v) begin
                dq.push_back(d);
                sent++;
            end
            hist.push_back(v);
            checks++;
            if (bus.out_valid !== hist[0]) begin
                failures++;
                $display("FAIL rand_valid sent=%0d out_valid=%b want %b", sent, bus.out_valid, hist[0]);
            end
            void'(hist.pop_front());
            if (bus.out_valid === 1'b1) begin
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_extra out_valid=1 with no sample outstanding");
                end else begin
                    logic [31:0] x;
                    x = dq.pop_front();
                    checks++;
                    if (x == 0) begin
                        if (bus.out_zero !== 1'b1 || bus.dout !== 12'h000) begin
                            failures++;
                            $display("FAIL rand_zero din=0 zero=%b dout=%h want 1/000", bus.out_zero, bus.dout);
                        end
                    end else begin
                        real diff;
                        diff = real'(bus.dout) - ideal_log(x);
                        // Truncation can land a hair beyond one LSB below the ideal value.
                        if (bus.out_zero !== 1'b0 || diff > 1.05 || diff < -1.05) begin
                            failures++;
                            $display("FAIL rand_value din=%h dout=%h zero=%b ideal=%f", x, bus.dout, bus.out_zero, ideal_log(x));
                        end
                    end
                    last_dout = bus.dout;
                    last_zero = bus.out_zero;
                end
            end else begin
                checks++;
                if (bus.dout !== last_dout || bus.out_zero !== last_zero) begin
                    failures++;
                    $display("FAIL rand_hold dout=%h zero=%b want %h/%b", bus.dout, bus.out_zero, last_dout, last_zero);
                end
            end
            if (sent >= 10000 && dq.size() == 0) break;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom | 32'h1);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_hold cyc=%0d out_valid=%b want 0", i, bus.out_valid);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_flush cyc=%0d out_valid=%b want 0", i, bus.out_valid);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.din      = '0;
        test_reset();
        test_back_to_back();
        test_zero();
        test_max();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
